aclk_key_entry: RTL

//  Keypad-side producer of the 4-digit key time consumed by the per-digit LCD drivers (key_ms_hr..key_ls_min).

---
 rtl/aclk_key_entry_if.sv | 27 ++
 rtl/aclk_key_entry.sv | 138 +++++++++++++
 2 files changed

// File: rtl/aclk_key_entry_if.sv
// Keypad-to-LCD key bus for aclk_key_entry.
// The master side drives the raw keypad level, the key code and the 1 Hz tick.
// The slave side, the key-entry block, returns the buffered digits and entry status.
interface aclk_key_entry_if;
  logic       key_down;
  logic [3:0] key_code;
  logic       one_second;
  logic [3:0] key_ms_hr;
  logic [3:0] key_ls_hr;
  logic [3:0] key_ms_min;
  logic [3:0] key_ls_min;
  logic [2:0] key_count;
  logic       entry_done;
  logic       entry_error;

  modport master (
    output key_down, key_code, one_second,
    input  key_ms_hr, key_ls_hr, key_ms_min, key_ls_min, key_count,
           entry_done, entry_error
  );

  modport slave (
    input  key_down, key_code, one_second,
    output key_ms_hr, key_ls_hr, key_ms_min, key_ls_min, key_count,
           entry_done, entry_error
  );
endinterface

// File: rtl/aclk_key_entry.sv
// Keypad key-entry block for the alarm clock.
// Debounces keypad presses and shifts decimal digits into a 4-digit buffer,
// newest digit in key_ls_min. A partial entry is cleared after TIMEOUT_SEC
// idle seconds, and entry_done pulses when the fourth digit lands.
// Build option: define ACLK_KEY_RANGE_CHECK_EN to reject completed entries
// outside 00:00..23:59. A rejected entry pulses entry_error and clears the buffer.
module aclk_key_entry #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_SEC     = 10
) (
  input logic              clock,
  input logic              reset,
  aclk_key_entry_if.slave  kbus
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TO_W = $clog2(TIMEOUT_SEC + 1);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, ACCEPT, WAIT_RELEASE} state_t;

  state_t          state, state_nxt;
  logic [DB_W-1:0] db_cnt;
  logic [TO_W-1:0] to_cnt;
  logic [3:0]      dig3, dig2, dig1, dig0;
  logic [2:0]      cnt;
  logic            done_r, err_r;
  logic            accept_digit;

  // Saturating increment for the debounce counter.
  function automatic logic [DB_W-1:0] db_inc(input logic [DB_W-1:0] v);
    return (int'(v) >= DEBOUNCE_CYCLES) ? v : v + DB_W'(1);
  endfunction

  // Saturating increment for the idle-seconds counter.
  function automatic logic [TO_W-1:0] to_inc(input logic [TO_W-1:0] v);
    return (int'(v) >= TIMEOUT_SEC) ? v : v + TO_W'(1);
  endfunction

`ifdef ACLK_KEY_RANGE_CHECK_EN
  // True when h1h0:m1m0 is a legal 24-hour time.
  function automatic logic entry_in_range(input logic [3:0] h1, h0, m1, m0);
    int hh, mm;
    hh = int'(h1) * 10 + int'(h0);
    mm = int'(m1) * 10 + int'(m0);
    return (hh <= 23) && (mm <= 59);
  endfunction
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: a key must stay down DEBOUNCE_CYCLES edges, then wait for release.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:         if (kbus.key_down) state_nxt = DEBOUNCE;
      DEBOUNCE: begin
        if (!kbus.key_down)                           state_nxt = IDLE;
        else if (int'(db_cnt) + 1 >= DEBOUNCE_CYCLES) state_nxt = ACCEPT;
      end
      ACCEPT:       state_nxt = WAIT_RELEASE;
      WAIT_RELEASE: if (!kbus.key_down) state_nxt = IDLE;
      default:      state_nxt = IDLE;
    endcase
  end

  // Output decode: ACCEPT lasts one cycle, so a digit is taken exactly once per press.
  always_comb begin
    accept_digit = (state == ACCEPT) && (kbus.key_code < 4'd10);
  end

  // Debounce counter: counts consecutive key_down cycles, cleared on any drop.
  always_ff @(posedge clock) begin
    if (reset) begin
      db_cnt <= '0;
    end else begin
      case (state)
        IDLE:     db_cnt <= kbus.key_down ? DB_W'(1) : '0;
        DEBOUNCE: db_cnt <= kbus.key_down ? db_inc(db_cnt) : '0;
        default:  db_cnt <= '0;
      endcase
    end
  end

  // Digit buffer, count, idle timeout and completion pulses; acceptance beats timeout.
  always_ff @(posedge clock) begin
    if (reset) begin
      dig3 <= '0; dig2 <= '0; dig1 <= '0; dig0 <= '0;
      cnt <= '0; to_cnt <= '0; done_r <= 1'b0; err_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      if (accept_digit) begin
        to_cnt <= '0;
        if (cnt == 3'd4) begin
          // A key after a complete entry starts a fresh one.
          dig3 <= '0; dig2 <= '0; dig1 <= '0; dig0 <= kbus.key_code;
          cnt  <= 3'd1;
        end else if (cnt == 3'd3) begin
`ifdef ACLK_KEY_RANGE_CHECK_EN
          if (entry_in_range(dig2, dig1, dig0, kbus.key_code)) begin
            dig3 <= dig2; dig2 <= dig1; dig1 <= dig0; dig0 <= kbus.key_code;
            cnt <= 3'd4; done_r <= 1'b1;
          end else begin
            dig3 <= '0; dig2 <= '0; dig1 <= '0; dig0 <= '0;
            cnt <= '0; err_r <= 1'b1;
          end
`else
          dig3 <= dig2; dig2 <= dig1; dig1 <= dig0; dig0 <= kbus.key_code;
          cnt <= 3'd4; done_r <= 1'b1;
`endif
        end else begin
          dig3 <= dig2; dig2 <= dig1; dig1 <= dig0; dig0 <= kbus.key_code;
          cnt <= cnt + 3'd1;
        end
      end else if (kbus.one_second && cnt != 3'd0 && cnt != 3'd4) begin
        if (int'(to_cnt) + 1 >= TIMEOUT_SEC) begin
          dig3 <= '0; dig2 <= '0; dig1 <= '0; dig0 <= '0;
          cnt <= '0; to_cnt <= '0;
        end else begin
          to_cnt <= to_inc(to_cnt);
        end
      end
    end
  end

  assign kbus.key_ms_hr   = dig3;
  assign kbus.key_ls_hr   = dig2;
  assign kbus.key_ms_min  = dig1;
  assign kbus.key_ls_min  = dig0;
  assign kbus.key_count   = cnt;
  assign kbus.entry_done  = done_r;
  assign kbus.entry_error = err_r;

endmodule
